registr_universal_module: RTL and testbench
===========================================

// Module: registr_universal_module
// PURPOSE
//  Parametrised universal shift register; successor to the serial-in/serial-out register.
//  Adds per-cycle mode select (shift L/R, rotate L/R, parallel load, clear), clock enable,
//  parallel in/out, and a bit counter that pulses word_valid per completed WIDTH-bit word.
//  Sits between serial links and word-wide datapaths; serves as deserializer or serializer.
// PARAMETERS
//  WIDTH  8  register width in bits; legal range 2..64
//  CNT_W  $clog2(WIDTH)  bit counter width; derived, never overridden
// PORTS
//  clk         in   1      single clock; all state updates on posedge
//  rst         in   1      synchronous reset, active-low
//  en          in   1      clock enable; 0 = all state held
//  mode        in   3      operation select, mode_e encoding below
//  ser_in      in   1      serial data in
//  par_in      in   WIDTH  parallel load data
//  ser_out     out  1      serial data out, combinational from register + dir_r
//  par_out     out  WIDTH  register contents
//  word_valid  out  1      registered 1-cycle pulse; WIDTH counted shifts completed
//  bit_cnt     out  CNT_W  shifts accumulated in current word (0..WIDTH-1)
// BEHAVIOUR
//  - Reset (rst==0 at posedge): overrides en and mode. par_out=0, bit_cnt=0,
//    word_valid=0, dir_r=0, so ser_out=0.
//  - en==0: register, bit_cnt and dir_r hold; word_valid=0 next cycle.
//  - mode, en==1, effect at next posedge:
//    000 HOLD : no change
//    001 SHL  : reg <= {reg[W-2:0], ser_in}; dir_r<=0; counts
//    010 SHR  : reg <= {ser_in, reg[W-1:1]}; dir_r<=1; counts
//    011 ROL  : reg <= {reg[W-2:0], reg[W-1]}; dir_r<=0; not counted
//    100 ROR  : reg <= {reg[0], reg[W-1:1]}; dir_r<=1; not counted
//    101 LOAD : reg <= par_in; bit_cnt<=0
//    110 CLEAR: reg <= 0; bit_cnt<=0
//    111 reserved; behaves as HOLD
//  - ser_out = dir_r ? reg[0] : reg[W-1]; bit leaving on the next shift in last direction.
//  - Counting: a counted shift with bit_cnt==WIDTH-1 wraps bit_cnt to 0 and sets
//    word_valid=1 for exactly one cycle; else bit_cnt+1, word_valid=0.
//  - word_valid with par_out: in the cycle word_valid==1, par_out holds the completed word.
//  - Mixing SHL and SHR within a word still counts each shift; direction is the user's concern.
//  - LOAD/CLEAR with bit_cnt==WIDTH-1: no pulse; counter restarts.
//  - Reset mid-word discards the partial word; the next pulse needs WIDTH new shifts.
//  - Unsigned arithmetic only; bit_cnt never reaches WIDTH.
// STRUCTURE
//  - Package registr_pkg: typedef enum logic [2:0] mode_e {MODE_HOLD, MODE_SHL, MODE_SHR,
//    MODE_ROL, MODE_ROR, MODE_LOAD, MODE_CLEAR, MODE_RSVD}.
//  - Sub-module registr_bit_counter #(WIDTH): inputs inc, clr; outputs cnt, wrap pulse.
//    Top holds the data register, dir_r and the mode decode.
// TESTING (WIDTH=8)
//  1. rst=0 for 2 cycles with mode=LOAD, par_in=8'hFF -> par_out=8'h00, bit_cnt=0,
//     word_valid=0, ser_out=0.
//  2. SHL, ser_in=1,0,1,1,0,0,1,0 over 8 cycles -> par_out=8'hB2 after 8th edge,
//     word_valid=1 that cycle only, bit_cnt=0.
//  3. LOAD 8'hA5, then SHR with ser_in=0 -> par_out=8'h52, ser_out=0, bit_cnt=1.
//  4. LOAD 8'h81; ROL -> 8'h03; ROR twice -> 8'h81, then 8'hC0; bit_cnt stays 0, word_valid 0.
//  5. SHL, 3 shifts; then en=0 for 4 cycles, ser_in toggling -> par_out and bit_cnt
//     frozen at 3; resume for 5 shifts -> word_valid pulses.
//  6. SHL, 5 shifts; rst=0 one cycle -> all zero; 7 further shifts no pulse, 8th pulses.

Source files
------------

// File: rtl/registr_pkg.sv
// Shared types for the universal shift register: per-cycle operation encoding.
package registr_pkg;

    typedef enum logic [2:0] {
        MODE_HOLD  = 3'b000,
        MODE_SHL   = 3'b001,
        MODE_SHR   = 3'b010,
        MODE_ROL   = 3'b011,
        MODE_ROR   = 3'b100,
        MODE_LOAD  = 3'b101,
        MODE_CLEAR = 3'b110,
        MODE_RSVD  = 3'b111
    } mode_e;

endpackage

// File: rtl/registr_bit_counter.sv
// Counts serial shifts modulo WIDTH; wrap is a registered one-cycle pulse on the completing shift.
// One-cycle latency from inc to wrap; no flow control, inc/clr are qualified by the caller.
module registr_bit_counter #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             wrap
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt  <= '0;
            wrap <= 1'b0;
        end else if (clr) begin
            cnt  <= '0;
            wrap <= 1'b0;
        end else if (inc) begin
            if (cnt == CNT_LAST) begin
                cnt  <= '0;
                wrap <= 1'b1;
            end else begin
                cnt  <= cnt + CNT_W'(1);
                wrap <= 1'b0;
            end
        end else begin
            wrap <= 1'b0;
        end
    end

endmodule

// File: rtl/registr_universal_module.sv
// Universal shift register (shift/rotate/load/clear) with per-word completion pulse.
// State updates one cycle after en/mode; ser_out is combinational from the register and last direction.
module registr_universal_module
    import registr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic             ser_in,
    input  logic [WIDTH-1:0] par_in,
    output logic             ser_out,
    output logic [WIDTH-1:0] par_out,
    output logic             word_valid,
    output logic [CNT_W-1:0] bit_cnt
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic             dir_q;
    logic             dir_d;
    logic             cnt_inc;
    logic             cnt_clr;
    mode_e            mode_sel;

    assign mode_sel = mode_e'(mode);

    always_comb begin
        data_d  = data_q;
        dir_d   = dir_q;
        cnt_inc = 1'b0;
        cnt_clr = 1'b0;
        if (en) begin
            case (mode_sel)
                MODE_SHL: begin
                    data_d  = {data_q[WIDTH-2:0], ser_in};
                    dir_d   = 1'b0;
                    cnt_inc = 1'b1;
                end
                MODE_SHR: begin
                    data_d  = {ser_in, data_q[WIDTH-1:1]};
                    dir_d   = 1'b1;
                    cnt_inc = 1'b1;
                end
                MODE_ROL: begin
                    data_d = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
                    dir_d  = 1'b0;
                end
                MODE_ROR: begin
                    data_d = {data_q[0], data_q[WIDTH-1:1]};
                    dir_d  = 1'b1;
                end
                MODE_LOAD: begin
                    data_d  = par_in;
                    cnt_clr = 1'b1;
                end
                MODE_CLEAR: begin
                    data_d  = '0;
                    cnt_clr = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            data_q <= '0;
            dir_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            dir_q  <= dir_d;
        end
    end

    // Rotates never count: they reorder bits already in the word rather than bring new ones in.
    registr_bit_counter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_bit_counter (
        .clk  (clk),
        .rst  (rst),
        .inc  (cnt_inc),
        .clr  (cnt_clr),
        .cnt  (bit_cnt),
        .wrap (word_valid)
    );

    assign par_out = data_q;
    assign ser_out = dir_q ? data_q[0] : data_q[WIDTH-1];

endmodule

// File: tb/tb_registr_universal_module.sv
// Directed self-checking bench for registr_universal_module at WIDTH=8.
module tb_registr_universal_module;

    localparam int WIDTH = 8;
    localparam int CNT_W = $clog2(WIDTH);

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic [2:0]       mode;
    logic             ser_in;
    logic [WIDTH-1:0] par_in;
    logic             ser_out;
    logic [WIDTH-1:0] par_out;
    logic             word_valid;
    logic [CNT_W-1:0] bit_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    registr_universal_module #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .mode       (mode),
        .ser_in     (ser_in),
        .par_in     (par_in),
        .ser_out    (ser_out),
        .par_out    (par_out),
        .word_valid (word_valid),
        .bit_cnt    (bit_cnt)
    );

    // Drive one cycle of inputs, then settle just past the edge for sampling.
    task automatic step(input logic [2:0] m, input logic s, input logic e);
        mode   = m;
        ser_in = s;
        en     = e;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst    = 1'b0;
        en     = 1'b1;
        mode   = 3'b101;
        par_in = 8'hFF;
        ser_in = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (par_out !== 8'h00) begin $display("FAIL reset_par_out got %h want 00", par_out); errors++; end
        checks++; if (bit_cnt !== 3'd0) begin $display("FAIL reset_bit_cnt got %0d want 0", bit_cnt); errors++; end
        checks++; if (word_valid !== 1'b0) begin $display("FAIL reset_word_valid got %b want 0", word_valid); errors++; end
        checks++; if (ser_out !== 1'b0) begin $display("FAIL reset_ser_out got %b want 0", ser_out); errors++; end
        rst = 1'b1;
    endtask

    task automatic test_shl_word;
        logic [7:0] bits;
        bits = 8'b1011_0010;
        for (int i = 0; i < 7; i++) step(3'b001, bits[7-i], 1'b1);
        checks++; if (bit_cnt !== 3'd7) begin $display("FAIL shl_cnt7 got %0d want 7", bit_cnt); errors++; end
        checks++; if (word_valid !== 1'b0) begin $display("FAIL shl_early_pulse got %b want 0", word_valid); errors++; end
        step(3'b001, bits[0], 1'b1);
        checks++; if (par_out !== 8'hB2) begin $display("FAIL shl_word got %h want b2", par_out); errors++; end
        checks++; if (word_valid !== 1'b1) begin $display("FAIL shl_pulse got %b want 1", word_valid); errors++; end
        checks++; if (bit_cnt !== 3'd0) begin $display("FAIL shl_wrap_cnt got %0d want 0", bit_cnt); errors++; end
        checks++; if (ser_out !== 1'b1) begin $display("FAIL shl_ser_out got %b want 1", ser_out); errors++; end
        step(3'b000, 1'b0, 1'b1);
        checks++; if (word_valid !== 1'b0) begin $display("FAIL shl_pulse_len got %b want 0", word_valid); errors++; end
        checks++; if (par_out !== 8'hB2) begin $display("FAIL hold_par got %h want b2", par_out); errors++; end
    endtask

    task automatic test_load_shr;
        par_in = 8'hA5;
        step(3'b101, 1'b0, 1'b1);
        checks++; if (par_out !== 8'hA5) begin $display("FAIL load_a5 got %h want a5", par_out); errors++; end
        step(3'b010, 1'b0, 1'b1);
        checks++; if (par_out !== 8'h52) begin $display("FAIL shr_par got %h want 52", par_out); errors++; end
        checks++; if (ser_out !== 1'b0) begin $display("FAIL shr_ser_out got %b want 0", ser_out); errors++; end
        checks++; if (bit_cnt !== 3'd1) begin $display("FAIL shr_cnt got %0d want 1", bit_cnt); errors++; end
    endtask

    task automatic test_rotate;
        par_in = 8'h81;
        step(3'b101, 1'b0, 1'b1);
        step(3'b011, 1'b0, 1'b1);
        checks++; if (par_out !== 8'h03) begin $display("FAIL rol got %h want 03", par_out); errors++; end
        checks++; if (ser_out !== 1'b0) begin $display("FAIL rol_ser_out got %b want 0", ser_out); errors++; end
        step(3'b100, 1'b0, 1'b1);
        checks++; if (par_out !== 8'h81) begin $display("FAIL ror1 got %h want 81", par_out); errors++; end
        checks++; if (ser_out !== 1'b1) begin $display("FAIL ror1_ser_out got %b want 1", ser_out); errors++; end
        step(3'b100, 1'b1, 1'b1);
        checks++; if (par_out !== 8'hC0) begin $display("FAIL ror2 got %h want c0", par_out); errors++; end
        checks++; if (bit_cnt !== 3'd0) begin $display("FAIL rot_cnt got %0d want 0", bit_cnt); errors++; end
        checks++; if (word_valid !== 1'b0) begin $display("FAIL rot_pulse got %b want 0", word_valid); errors++; end
    endtask

    task automatic test_enable_hold;
        step(3'b110, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(3'b001, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) step(3'b001, i[0], 1'b0);
        checks++; if (par_out !== 8'h07) begin $display("FAIL en_hold_par got %h want 07", par_out); errors++; end
        checks++; if (bit_cnt !== 3'd3) begin $display("FAIL en_hold_cnt got %0d want 3", bit_cnt); errors++; end
        for (int i = 0; i < 4; i++) step(3'b001, 1'b0, 1'b1);
        checks++; if (word_valid !== 1'b0) begin $display("FAIL en_resume_early got %b want 0", word_valid); errors++; end
        step(3'b001, 1'b0, 1'b1);
        checks++; if (word_valid !== 1'b1) begin $display("FAIL en_resume_pulse got %b want 1", word_valid); errors++; end
        checks++; if (par_out !== 8'hE0) begin $display("FAIL en_resume_par got %h want e0", par_out); errors++; end
        step(3'b001, 1'b1, 1'b0);
        checks++; if (word_valid !== 1'b0) begin $display("FAIL en_low_pulse got %b want 0", word_valid); errors++; end
        checks++; if (par_out !== 8'hE0) begin $display("FAIL en_low_par got %h want e0", par_out); errors++; end
    endtask

    task automatic test_reset_mid_word;
        step(3'b110, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) step(3'b001, 1'b1, 1'b1);
        checks++; if (par_out !== 8'h1F) begin $display("FAIL mid_pre got %h want 1f", par_out); errors++; end
        rst = 1'b0;
        step(3'b001, 1'b1, 1'b1);
        rst = 1'b1;
        checks++; if (par_out !== 8'h00) begin $display("FAIL mid_rst_par got %h want 00", par_out); errors++; end
        checks++; if (bit_cnt !== 3'd0) begin $display("FAIL mid_rst_cnt got %0d want 0", bit_cnt); errors++; end
        for (int i = 0; i < 7; i++) step(3'b001, 1'b1, 1'b1);
        checks++; if (word_valid !== 1'b0) begin $display("FAIL mid_no_pulse got %b want 0", word_valid); errors++; end
        checks++; if (par_out !== 8'h7F) begin $display("FAIL mid_7_par got %h want 7f", par_out); errors++; end
        step(3'b001, 1'b1, 1'b1);
        checks++; if (word_valid !== 1'b1) begin $display("FAIL mid_pulse got %b want 1", word_valid); errors++; end
        checks++; if (par_out !== 8'hFF) begin $display("FAIL mid_word got %h want ff", par_out); errors++; end
    endtask

    task automatic test_load_at_wrap;
        step(3'b110, 1'b0, 1'b1);
        step(3'b001, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) step(3'b010, 1'b0, 1'b1);
        checks++; if (bit_cnt !== 3'd7) begin $display("FAIL mixed_cnt got %0d want 7", bit_cnt); errors++; end
        par_in = 8'h5A;
        step(3'b101, 1'b0, 1'b1);
        checks++; if (word_valid !== 1'b0) begin $display("FAIL load_wrap_pulse got %b want 0", word_valid); errors++; end
        checks++; if (bit_cnt !== 3'd0) begin $display("FAIL load_wrap_cnt got %0d want 0", bit_cnt); errors++; end
        step(3'b111, 1'b1, 1'b1);
        checks++; if (par_out !== 8'h5A) begin $display("FAIL rsvd_par got %h want 5a", par_out); errors++; end
        checks++; if (bit_cnt !== 3'd0) begin $display("FAIL rsvd_cnt got %0d want 0", bit_cnt); errors++; end
    endtask

    initial begin
        rst    = 1'b0;
        en     = 1'b0;
        mode   = 3'b000;
        ser_in = 1'b0;
        par_in = '0;
        #2;
        test_reset;
        test_shl_word;
        test_load_shr;
        test_rotate;
        test_enable_hold;
        test_reset_mid_word;
        test_load_at_wrap;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
